// File: rtl/sata_rx_prim_if.sv
// Receive dword stream into the primitive decoder and its decoded outputs.
// align_cnt/err_cnt are only driven with counters when RXP_STATS_EN is defined.
interface sata_rx_prim_if #(
    parameter int C_CNT_W = 16
);
    logic               rx_ce;
    logic               link_up;
    logic [31:0]        rxdata;
    logic [3:0]         rxdatak;
    logic               prim_valid;
    logic [4:0]         prim_code;
    logic               data_valid;
    logic [31:0]        data;
    logic               rx_err;
    logic [C_CNT_W-1:0] align_cnt;
    logic [C_CNT_W-1:0] err_cnt;

    modport master (
        output rx_ce, link_up, rxdata, rxdatak,
        input  prim_valid, prim_code, data_valid, data, rx_err, align_cnt, err_cnt
    );

    modport slave (
        input  rx_ce, link_up, rxdata, rxdatak,
        output prim_valid, prim_code, data_valid, data, rx_err, align_cnt, err_cnt
    );
endinterface

// File: rtl/sata_rx_prim.sv
// SATA receive primitive decoder: drops ALIGNp, decodes primitives, expands CONTp.
// Optional ALIGN/error statistics counters are built when RXP_STATS_EN is defined.
module sata_rx_prim #(
    parameter int C_CNT_W = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    sata_rx_prim_if.slave  rx
);
    localparam logic [4:0] C_CONT = 5'd17;

    // state  | meaning
    // S_IDLE | no primitive seen since link-up or last data
    // S_PRIM | last_prim holds the most recent primitive
    // S_CONT | CONTp repetition active, data dwords are scrambled junk
    typedef enum logic [1:0] {S_IDLE, S_PRIM, S_CONT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  last_q, last_d;
    logic        pv_q, pv_d;
    logic        dv_q, dv_d;
    logic        err_q, err_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] data_q, data_d;

    logic        is_align, is_prim, is_data;
    logic [4:0]  lookup;

    function automatic logic [4:0] prim_lookup(input logic [31:0] d);
        case (d)
            32'hB5B5957C: prim_lookup = 5'd1;
            32'h5757B57C: prim_lookup = 5'd2;
            32'h4A4A957C: prim_lookup = 5'd3;
            32'h3737B57C: prim_lookup = 5'd4;
            32'hD5D5B57C: prim_lookup = 5'd5;
            32'hD5D5AA7C: prim_lookup = 5'd6;
            32'h9595AA7C: prim_lookup = 5'd7;
            32'h5555B57C: prim_lookup = 5'd8;
            32'h3535B57C: prim_lookup = 5'd9;
            32'h5656B57C: prim_lookup = 5'd10;
            32'h5858B57C: prim_lookup = 5'd11;
            32'h3636B57C: prim_lookup = 5'd12;
            32'h1717B57C: prim_lookup = 5'd13;
            32'h7575957C: prim_lookup = 5'd14;
            32'h9595957C: prim_lookup = 5'd15;
            32'hF5F5957C: prim_lookup = 5'd16;
            32'h9999AA7C: prim_lookup = 5'd17;
            default:      prim_lookup = 5'd0;
        endcase
    endfunction

    assign is_align = (rx.rxdatak == 4'b0001) && (rx.rxdata[7:0] == 8'hBC);
    assign is_prim  = (rx.rxdatak == 4'b0001) && (rx.rxdata[7:0] == 8'h7C);
    assign is_data  = (rx.rxdatak == 4'b0000);
    assign lookup   = prim_lookup(rx.rxdata);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        pv_d    = 1'b0;
        dv_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        data_d  = data_q;
        if (!rx.link_up) begin
            state_d = S_IDLE;
            last_d  = 5'd0;
        end else if (rx.rx_ce) begin
            if (is_align) begin
                state_d = state_q;
            end else if (is_data) begin
                if (state_q == S_CONT) begin
                    pv_d   = 1'b1;
                    code_d = last_q;
                end else begin
                    dv_d    = 1'b1;
                    data_d  = rx.rxdata;
                    state_d = S_IDLE;
                end
            end else if (is_prim) begin
                if (lookup == 5'd0) begin
                    err_d = 1'b1;
                end else if (lookup == C_CONT) begin
                    // CONT without a known primitive to repeat is a protocol error
                    if (state_q == S_IDLE)
                        err_d = 1'b1;
                    else
                        state_d = S_CONT;
                end else begin
                    pv_d    = 1'b1;
                    code_d  = lookup;
                    last_d  = lookup;
                    state_d = S_PRIM;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 5'd0;
            pv_q    <= 1'b0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 5'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pv_q    <= pv_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            code_q  <= code_d;
            data_q  <= data_d;
        end
    end

    assign rx.prim_valid = pv_q;
    assign rx.prim_code  = code_q;
    assign rx.data_valid = dv_q;
    assign rx.data       = data_q;
    assign rx.rx_err     = err_q;

`ifdef RXP_STATS_EN
    logic [C_CNT_W-1:0] align_cnt_q;
    logic [C_CNT_W-1:0] err_cnt_q;
    logic               align_hit;

    assign align_hit = rx.link_up && rx.rx_ce && is_align;

    // saturating; unaffected by link_up so counts survive link drops
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            align_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (align_hit && (align_cnt_q != '1))
                align_cnt_q <= align_cnt_q + 1'b1;
            if (err_d && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign rx.align_cnt = align_cnt_q;
    assign rx.err_cnt   = err_cnt_q;
`else
    assign rx.align_cnt = '0;
    assign rx.err_cnt   = '0;
`endif
endmodule

// File: tb/tb_sata_rx_prim.sv
// Directed self-checking bench for sata_rx_prim; expected values are hand-computed.
module tb_sata_rx_prim;
    localparam int C_CNT_W = 16;

    localparam logic [31:0] D_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] D_XRDY  = 32'h5757B57C;
    localparam logic [31:0] D_SOF   = 32'h3737B57C;
    localparam logic [31:0] D_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] D_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] D_RIP   = 32'h5555B57C;
    localparam logic [31:0] D_CONT  = 32'h9999AA7C;

    logic sys_clk;
    logic sys_rst_n;
    int   n_chk;
    int   n_err;

    sata_rx_prim_if #(.C_CNT_W(C_CNT_W)) rx_if ();

    sata_rx_prim #(.C_CNT_W(C_CNT_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx_if)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ce, input logic lu, input logic [31:0] d, input logic [3:0] k);
        rx_if.rx_ce   = ce;
        rx_if.link_up = lu;
        rx_if.rxdata  = d;
        rx_if.rxdatak = k;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic pv, input logic [4:0] code,
                              input logic dv, input logic [31:0] dat, input logic er);
        chk({tag, ".prim_valid"}, {31'd0, rx_if.prim_valid}, {31'd0, pv});
        chk({tag, ".data_valid"}, {31'd0, rx_if.data_valid}, {31'd0, dv});
        chk({tag, ".rx_err"},     {31'd0, rx_if.rx_err},     {31'd0, er});
        if (pv) chk({tag, ".prim_code"}, {27'd0, rx_if.prim_code}, {27'd0, code});
        if (dv) chk({tag, ".data"}, rx_if.data, dat);
    endtask

    task automatic expect_none(input string tag);
        expect_out(tag, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic expect_prim(input string tag, input logic [4:0] code);
        expect_out(tag, 1'b1, code, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic expect_data(input string tag, input logic [31:0] dat);
        expect_out(tag, 1'b0, 5'd0, 1'b1, dat, 1'b0);
    endtask

    task automatic expect_err(input string tag);
        expect_out(tag, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic check_cnts(input string tag, input int exp_align, input int exp_err);
`ifdef RXP_STATS_EN
        chk({tag, ".align_cnt"}, 32'(rx_if.align_cnt), 32'(exp_align));
        chk({tag, ".err_cnt"},   32'(rx_if.err_cnt),   32'(exp_err));
`else
        chk({tag, ".align_cnt"}, 32'(rx_if.align_cnt), 32'd0);
        chk({tag, ".err_cnt"},   32'(rx_if.err_cnt),   32'd0);
        if (exp_align < 0 || exp_err < 0) $display("negative count argument in %s", tag);
`endif
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        sys_rst_n     = 1'b0;
        rx_if.rx_ce   = 1'b0;
        rx_if.link_up = 1'b0;
        rx_if.rxdata  = 32'd0;
        rx_if.rxdatak = 4'd0;

        repeat (2) @(posedge sys_clk);
        #1;
        expect_none("reset");
        chk("reset.prim_code", {27'd0, rx_if.prim_code}, 32'd0);
        chk("reset.data", rx_if.data, 32'd0);
        check_cnts("reset", 0, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // ALIGNs dropped
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, D_ALIGN, 4'b0001);
            expect_none($sformatf("align%0d", i));
        end
        check_cnts("align", 4, 0);

        // X_RDY, CONT, junk x3, SOF
        step(1'b1, 1'b1, D_XRDY, 4'b0001);  expect_prim("t2.xrdy", 5'd2);
        step(1'b1, 1'b1, D_CONT, 4'b0001);  expect_none("t2.cont");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h12345678, 4'b0000);
            expect_prim($sformatf("t2.rep%0d", i), 5'd2);
        end
        step(1'b1, 1'b1, D_ALIGN, 4'b0001); expect_none("t2.align_in_cont");
        step(1'b1, 1'b1, D_CONT, 4'b0001);  expect_none("t2.cont_again");
        step(1'b1, 1'b1, D_SOF, 4'b0001);   expect_prim("t2.sof", 5'd4);

        // frame with payload
        step(1'b1, 1'b1, D_SOF, 4'b0001);        expect_prim("t3.sof", 5'd4);
        step(1'b1, 1'b1, 32'hDEADBEEF, 4'b0000); expect_data("t3.d0", 32'hDEADBEEF);
        step(1'b1, 1'b1, 32'h00000001, 4'b0000); expect_data("t3.d1", 32'h00000001);
        step(1'b1, 1'b1, D_EOF, 4'b0001);        expect_prim("t3.eof", 5'd5);

        // errors: bad K, CONT from idle, unknown primitive
        step(1'b1, 1'b1, 32'h11223344, 4'b0010); expect_err("t4.badk");
        step(1'b1, 1'b1, 32'h0, 4'b0000);        expect_data("t4.to_idle", 32'h0);
        step(1'b1, 1'b1, D_CONT, 4'b0001);       expect_err("t4.cont_idle");
        step(1'b1, 1'b1, 32'h0000007C, 4'b0001); expect_err("t4.unknown");
        check_cnts("t4", 4, 3);

        // link drop during CONT
        step(1'b1, 1'b1, D_RIP, 4'b0001);        expect_prim("t5.rip", 5'd8);
        step(1'b1, 1'b1, D_CONT, 4'b0001);       expect_none("t5.cont");
        step(1'b1, 1'b0, 32'h12345678, 4'b0000); expect_none("t5.link_down");
        step(1'b1, 1'b1, 32'hAAAA5555, 4'b0000); expect_data("t5.data", 32'hAAAA5555);
        step(1'b1, 1'b1, D_RIP, 4'b0001);        expect_prim("t5.rip2", 5'd8);
        step(1'b1, 1'b1, D_CONT, 4'b0001);       expect_none("t5.cont2");
        step(1'b1, 1'b0, D_ALIGN, 4'b0001);      expect_none("t5.link_down2");
        step(1'b1, 1'b1, D_CONT, 4'b0001);       expect_err("t5.cont_after_up");

        // rx_ce gaps
        step(1'b1, 1'b1, D_HOLD, 4'b0001);       expect_prim("t6.hold", 5'd6);
        step(1'b0, 1'b1, D_SOF, 4'b0001);        expect_none("t6.gap0");
        step(1'b1, 1'b1, D_CONT, 4'b0001);       expect_none("t6.cont");
        step(1'b0, 1'b1, 32'h55555555, 4'b0000); expect_none("t6.gap1");
        step(1'b1, 1'b1, 32'h0BADF00D, 4'b0000); expect_prim("t6.rep0", 5'd6);
        step(1'b0, 1'b1, 32'h0BADF00D, 4'b0010); expect_none("t6.gap2");
        step(1'b1, 1'b1, 32'hCAFEF00D, 4'b0000); expect_prim("t6.rep1", 5'd6);
        step(1'b0, 1'b1, D_ALIGN, 4'b0001);      expect_none("t6.gap3");
        check_cnts("final", 4, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
